// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: state encoding
// and the sizing rule for the bit counter.
package add_sub_pkg;

  // State encoding shared with anything that needs to decode the FSM.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_RUN  = RUN,
    S_DONE = DONE
  } state_e;

  // Bit counter width: $clog2(width) bits, with a floor of one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    if (width > 32'd1) begin
      return $clog2(width);
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// Single-bit full adder.
// This is the only arithmetic element used by the serial adder/subtractor.
module fullAdder (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit two's-complement adder/subtractor.
// Operands are captured on start and processed one bit per clock, LSB first,
// through a single full adder. Subtraction adds ~b with a carry-in of 1.
// done pulses for one cycle when result/cout/ovf are final.
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_sum;
  logic             fa_cout;

  fullAdder u_fa (
    .sum  (fa_sum),
    .cout (fa_cout),
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q)
  );

  // Next-state logic: operand capture in IDLE, one bit per cycle in RUN.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // The sum bit enters at the MSB so that after WIDTH shifts the
        // first (LSB) sum bit has reached bit 0.
        result_d = {fa_sum, result_q[WIDTH-1:1]};
        opa_d    = {1'b0, opa_q[WIDTH-1:1]};
        opb_d    = {1'b0, opb_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        if (cnt_q == LAST_BIT) begin
          // carry_q is the carry into the MSB; fa_cout is the carry out.
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule
